// File: rtl/invader_formation_renderer.sv
// Invader formation pixel source (RGB one clock after X/Y) plus march/drop/halt motion FSM and alive bitmap.
// Optional SPEEDUP_EN: step interval shrinks as invaders die; no backpressure, kills are single-cycle strobes.
module invader_formation_renderer #(
    parameter int COLS            = 8,
    parameter int ROWS            = 4,
    parameter int CELL_W          = 32,
    parameter int CELL_H          = 16,
    parameter int SPR_W           = 16,
    parameter int SPR_H           = 8,
    parameter int FRAME_WIDTH     = 400,
    parameter int START_X         = 16,
    parameter int START_Y         = 40,
    parameter int STEP_PX         = 4,
    parameter int DROP_PX         = 8,
    parameter int BOTTOM_Y        = 560,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [11:0] X,
    input  logic [11:0] Y,
    input  logic        KILL_VALID,
    input  logic [2:0]  KILL_ROW,
    input  logic [3:0]  KILL_COL,
    output logic        R,
    output logic        G,
    output logic        B,
    output logic [11:0] FORM_X,
    output logic [11:0] FORM_Y,
    output logic [5:0]  ALIVE_CNT,
    output logic        REACHED_BOTTOM,
    output logic        FRAME_TICK
);
    localparam int NUM   = ROWS * COLS;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SX_W  = $clog2(CELL_W);
    localparam int SY_W  = $clog2(CELL_H);
    localparam int SXP_W = SX_W + 1;
    localparam int SYP_W = SY_W + 1;
    localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);

    localparam logic [12:0]      FORM_W_C  = 13'(COLS * CELL_W);
    localparam logic [12:0]      FORM_H_C  = 13'(ROWS * CELL_H);
    localparam logic [12:0]      STEP_C13  = 13'(STEP_PX);
    localparam logic [11:0]      STEP_C    = 12'(STEP_PX);
    localparam logic [11:0]      DROP_C    = 12'(DROP_PX);
    localparam logic [12:0]      WIDTH_C   = 13'(FRAME_WIDTH);
    localparam logic [12:0]      BOTTOM_C  = 13'(BOTTOM_Y);
    localparam logic [11:0]      START_X_C = 12'(START_X);
    localparam logic [11:0]      START_Y_C = 12'(START_Y);
    localparam logic [5:0]       NUM_C     = 6'(NUM);
    localparam logic [SXP_W-1:0] SPR_W_C   = SXP_W'(SPR_W);
    localparam logic [SYP_W-1:0] SPR_H_C   = SYP_W'(SPR_H);
    localparam logic [3:0]       ROWS_C    = 4'(ROWS);
    localparam logic [4:0]       COLS_C    = 5'(COLS);
    localparam logic [IDX_W-1:0] COLS_IDX  = IDX_W'(COLS);

    typedef enum logic [1:0] {
        S_MOVE_R = 2'd0,
        S_MOVE_L = 2'd1,
        S_HALT   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [11:0]      r_form_x;
    logic [11:0]      r_form_y;
    logic [11:0]      w_form_x_nxt;
    logic [11:0]      w_form_y_nxt;
    logic             w_set_bottom;
    logic [NUM-1:0]   r_alive;
    logic [5:0]       r_alive_cnt;
    logic [11:0]      r_y_prev;
    logic             r_tick;
    logic             r_reached;
    logic             r_r;
    logic             r_g;
    logic             r_b;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_interval;
    logic [CNT_W-1:0] w_int_m1;

    // ---------------- render ----------------
    logic [11:0]      w_lx;
    logic [11:0]      w_ly;
    logic             w_inside;
    logic [SX_W-1:0]  w_sx;
    logic [SY_W-1:0]  w_sy;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [IDX_W-1:0] w_pix_idx;
    logic             w_eye;
    logic             w_lit;

    assign w_lx = X - r_form_x;
    assign w_ly = Y - r_form_y;
    // Once X >= FORM_X holds, lx cannot wrap, so the far-edge test is just lx < formation width.
    assign w_inside = (X >= r_form_x) && ({1'b0, w_lx} < FORM_W_C) &&
                      (Y >= r_form_y) && ({1'b0, w_ly} < FORM_H_C);
    assign w_sx      = w_lx[SX_W-1:0];
    assign w_sy      = w_ly[SY_W-1:0];
    assign w_col     = w_lx[SX_W +: COL_W];
    assign w_row     = w_ly[SY_W +: ROW_W];
    assign w_pix_idx = IDX_W'(w_row) * COLS_IDX + IDX_W'(w_col);
    assign w_eye     = (w_sy == SY_W'(2)) &&
                       ((w_sx == SX_W'(4))  || (w_sx == SX_W'(5)) ||
                        (w_sx == SX_W'(10)) || (w_sx == SX_W'(11)));
    assign w_lit     = w_inside && ({1'b0, w_sx} < SPR_W_C) && ({1'b0, w_sy} < SPR_H_C) &&
                       r_alive[w_pix_idx] && !w_eye;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_r <= 1'b0;
            r_g <= 1'b0;
            r_b <= 1'b0;
        end else begin
            r_r <= w_lit && (w_row == '0);
            r_g <= w_lit && (w_row != '0);
            r_b <= w_lit && (w_row == '0);
        end
    end

    // ---------------- frame detect / step timing ----------------
    logic w_run;
    logic w_step;

    always_comb begin
        w_interval = FRAMES_PER_STEP[CNT_W-1:0];
`ifdef SPEEDUP_EN
        if (r_alive_cnt > 6'(NUM / 2)) begin
            w_interval = CNT_W'(FRAMES_PER_STEP);
        end else if (r_alive_cnt > 6'(NUM / 8)) begin
            w_interval = CNT_W'(FRAMES_PER_STEP >> 1);
        end else begin
            w_interval = CNT_W'(FRAMES_PER_STEP >> 2);
        end
`endif
    end

    assign w_int_m1 = w_interval - CNT_W'(1);
    assign w_run    = (r_state != S_HALT) && (r_alive_cnt != 6'd0);
    // >= rather than == so a shortened interval fires on the very next tick.
    assign w_step   = w_run && r_tick && (r_frame_cnt >= w_int_m1);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_y_prev    <= 12'd0;
            r_tick      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_y_prev <= Y;
            r_tick   <= (r_y_prev != 12'd0) && (Y == 12'd0);
            if (w_run && r_tick) begin
                r_frame_cnt <= w_step ? '0 : r_frame_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- motion FSM ----------------
    logic        w_hit_right;
    logic        w_hit_left;
    logic [11:0] w_drop_y;
    logic        w_hit_bottom;

    assign w_hit_right  = ({1'b0, r_form_x} + STEP_C13 + FORM_W_C) > WIDTH_C;
    assign w_hit_left   = r_form_x < STEP_C;
    assign w_drop_y     = r_form_y + DROP_C;
    assign w_hit_bottom = ({1'b0, w_drop_y} + FORM_H_C) >= BOTTOM_C;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= S_MOVE_R;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_alive_cnt == 6'd0) begin
            w_state_nxt = S_HALT;
        end else if (w_step) begin
            case (r_state)
                S_MOVE_R: if (w_hit_right) w_state_nxt = w_hit_bottom ? S_HALT : S_MOVE_L;
                S_MOVE_L: if (w_hit_left)  w_state_nxt = w_hit_bottom ? S_HALT : S_MOVE_R;
                default:  w_state_nxt = S_HALT;
            endcase
        end
    end

    always_comb begin
        w_form_x_nxt = r_form_x;
        w_form_y_nxt = r_form_y;
        w_set_bottom = 1'b0;
        if (w_step) begin
            case (r_state)
                S_MOVE_R: begin
                    if (w_hit_right) begin
                        w_form_y_nxt = w_drop_y;
                        w_set_bottom = w_hit_bottom;
                    end else begin
                        w_form_x_nxt = r_form_x + STEP_C;
                    end
                end
                S_MOVE_L: begin
                    if (w_hit_left) begin
                        w_form_y_nxt = w_drop_y;
                        w_set_bottom = w_hit_bottom;
                    end else begin
                        w_form_x_nxt = r_form_x - STEP_C;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_form_x  <= START_X_C;
            r_form_y  <= START_Y_C;
            r_reached <= 1'b0;
        end else begin
            r_form_x  <= w_form_x_nxt;
            r_form_y  <= w_form_y_nxt;
            r_reached <= r_reached | w_set_bottom;
        end
    end

    // ---------------- kill port ----------------
    logic             w_kill_in_range;
    logic [IDX_W-1:0] w_kill_idx;
    logic             w_kill_hit;

    assign w_kill_in_range = ({1'b0, KILL_ROW} < ROWS_C) && ({1'b0, KILL_COL} < COLS_C);
    assign w_kill_idx      = IDX_W'(KILL_ROW) * COLS_IDX + IDX_W'(KILL_COL);
    assign w_kill_hit      = KILL_VALID && w_kill_in_range && r_alive[w_kill_idx];

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_alive     <= '1;
            r_alive_cnt <= NUM_C;
        end else if (w_kill_hit) begin
            r_alive[w_kill_idx] <= 1'b0;
            r_alive_cnt         <= r_alive_cnt - 6'd1;
        end
    end

    assign R              = r_r;
    assign G              = r_g;
    assign B              = r_b;
    assign FORM_X         = r_form_x;
    assign FORM_Y         = r_form_y;
    assign ALIVE_CNT      = r_alive_cnt;
    assign REACHED_BOTTOM = r_reached;
    assign FRAME_TICK     = r_tick;
endmodule
